// File: rtl/issue_ctrl_pkg.sv
// Shared definitions for the issue scheduler: default back-end sizes,
// tag width and the scheduler FSM state encoding.
package issue_ctrl_pkg;

  localparam int unsigned ROB_SIZE_DEF = 16;
  localparam int unsigned RS_SIZE_DEF  = 16;
  localparam int unsigned LSB_SIZE_DEF = 16;
  localparam int unsigned TAG_W_DEF    = 5;

  // Tag 0 is reserved to mean "no dependency"; real ROB tags are 1..ROB_SIZE.
  localparam logic [TAG_W_DEF-1:0] TAG_NULL = '0;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/issue_ctrl_slot_counter.sv
// slot_counter: saturating up/down occupancy counter for one back-end
// resource (ROB, RS or LSB).
//   clk, rst : clock, synchronous active-high reset
//   en       : global ready; low holds the count
//   clr      : clear to zero (flush), wins over inc/dec
//   inc, dec : one slot allocated / freed this cycle
//   full     : count == DEPTH (registered)
//   empty    : count == 0     (registered)
module slot_counter #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             inc_eff, dec_eff;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign inc_eff = inc & ~full;
  assign dec_eff = dec & ~empty;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (clr) begin
        cnt_d = '0;
      end else begin
        case ({inc_eff, dec_eff})
          2'b10:   cnt_d = cnt_q + CNT_W'(1);
          2'b01:   cnt_d = cnt_q - CNT_W'(1);
          default: cnt_d = cnt_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/issue_ctrl.sv
// issue_ctrl: decides each cycle whether the decoded head instruction may
// issue, pops the instruction queue, hands out ROB tags and tracks
// ROB/RS/LSB occupancy; recovers from flush via a one-cycle FLUSH state.
//   rdy          : global ready, low freezes everything
//   iq_empty     : instruction queue empty
//   id_valid     : decoder holds a legal instruction
//   id_is_ls     : instruction targets the LSB (else RS)
//   rob_commit   : ROB retired its head
//   rs_release   : one RS slot freed
//   lsb_release  : one LSB slot freed
//   flush        : discard all speculative state
//   iq_pop       : dequeue IQ head (same as issue_valid)
//   issue_valid  : dispatch current instruction
//   issue_to_lsb : dispatch target is the LSB
//   issue_tag    : ROB tag for the issuing instruction (rob_tail + 1)
//   rob_full     : registered ROB occupancy at capacity
//   stall        : instruction present but not issued
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int unsigned ROB_SIZE = ROB_SIZE_DEF,
  parameter int unsigned RS_SIZE  = RS_SIZE_DEF,
  parameter int unsigned LSB_SIZE = LSB_SIZE_DEF,
  parameter int unsigned TAG_W    = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             iq_empty,
  input  logic             id_valid,
  input  logic             id_is_ls,
  input  logic             rob_commit,
  input  logic             rs_release,
  input  logic             lsb_release,
  input  logic             flush,
  output logic             iq_pop,
  output logic             issue_valid,
  output logic             issue_to_lsb,
  output logic [TAG_W-1:0] issue_tag,
  output logic             rob_full,
  output logic             stall
);

  localparam int unsigned PTR_W = $clog2(ROB_SIZE);

  state_e           state_q, state_d;
  logic [PTR_W-1:0] rob_head_q, rob_head_d;
  logic [PTR_W-1:0] rob_tail_q, rob_tail_d;

  logic rob_full_w, rob_empty, rs_full, rs_empty, lsb_full, lsb_empty;
  logic run, can_issue, commit_eff, rs_dec, lsb_dec;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(ROB_SIZE - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign run = (state_q == ST_RUN);

  // Capacity uses registered counts only, so a same-cycle release never
  // unblocks a full resource.
  assign can_issue = rdy & run & ~flush & ~iq_empty & id_valid & ~rob_full_w &
                     (id_is_ls ? ~lsb_full : ~rs_full);

  // Commits/releases are dropped in FLUSH and when the resource is already
  // empty, keeping head pointer and counts consistent.
  assign commit_eff = rdy & run & rob_commit & ~rob_empty;
  assign rs_dec     = rdy & run & rs_release & ~rs_empty;
  assign lsb_dec    = rdy & run & lsb_release & ~lsb_empty;

  assign iq_pop       = can_issue;
  assign issue_valid  = can_issue;
  assign issue_to_lsb = can_issue & id_is_ls;
  assign issue_tag    = TAG_W'(rob_tail_q) + TAG_W'(1);
  assign rob_full     = rob_full_w;
  assign stall        = rdy & ~iq_empty & id_valid & ~can_issue;

  always_comb begin
    state_d    = state_q;
    rob_head_d = rob_head_q;
    rob_tail_d = rob_tail_q;
    if (rdy) begin
      state_d = flush ? ST_FLUSH : ST_RUN;
      if (commit_eff) rob_head_d = ptr_inc(rob_head_q);
      // On flush the ROB empties: tail collapses onto the post-commit head.
      if (flush)          rob_tail_d = rob_head_d;
      else if (can_issue) rob_tail_d = ptr_inc(rob_tail_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      rob_head_q <= '0;
      rob_tail_q <= '0;
    end else begin
      state_q    <= state_d;
      rob_head_q <= rob_head_d;
      rob_tail_q <= rob_tail_d;
    end
  end

  slot_counter #(.DEPTH(ROB_SIZE)) u_rob_cnt (
    .clk(clk), .rst(rst), .en(rdy), .clr(flush),
    .inc(can_issue), .dec(commit_eff),
    .full(rob_full_w), .empty(rob_empty)
  );

  slot_counter #(.DEPTH(RS_SIZE)) u_rs_cnt (
    .clk(clk), .rst(rst), .en(rdy), .clr(flush),
    .inc(can_issue & ~id_is_ls), .dec(rs_dec),
    .full(rs_full), .empty(rs_empty)
  );

  slot_counter #(.DEPTH(LSB_SIZE)) u_lsb_cnt (
    .clk(clk), .rst(rst), .en(rdy), .clr(flush),
    .inc(can_issue & id_is_ls), .dec(lsb_dec),
    .full(lsb_full), .empty(lsb_empty)
  );

endmodule

// File: tb/tb_issue_ctrl.sv
module tb_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst, rdy, iq_empty, id_valid, id_is_ls;
  logic       rob_commit, rs_release, lsb_release, flush;
  logic       iq_pop, issue_valid, issue_to_lsb, rob_full, stall;
  logic [4:0] issue_tag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  issue_ctrl #(
    .ROB_SIZE(16), .RS_SIZE(16), .LSB_SIZE(16), .TAG_W(5)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .iq_empty(iq_empty), .id_valid(id_valid), .id_is_ls(id_is_ls),
    .rob_commit(rob_commit), .rs_release(rs_release),
    .lsb_release(lsb_release), .flush(flush),
    .iq_pop(iq_pop), .issue_valid(issue_valid), .issue_to_lsb(issue_to_lsb),
    .issue_tag(issue_tag), .rob_full(rob_full), .stall(stall)
  );

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", nm, obs, exp_v);
    end
  endtask

  task automatic exp_out(input string nm, input int pop, input int lsb,
                         input int tag, input int full, input int st);
    chk({nm, ".iq_pop"},       32'(iq_pop),       32'(pop));
    chk({nm, ".issue_valid"},  32'(issue_valid),  32'(pop));
    chk({nm, ".issue_to_lsb"}, 32'(issue_to_lsb), 32'(lsb));
    chk({nm, ".issue_tag"},    32'(issue_tag),    32'(tag));
    chk({nm, ".rob_full"},     32'(rob_full),     32'(full));
    chk({nm, ".stall"},        32'(stall),        32'(st));
  endtask

  // Inputs: iq_empty, id_valid, id_is_ls, rob_commit, rs_release, lsb_release, flush
  task automatic drv(input logic e, input logic v, input logic ls, input logic c,
                     input logic rr, input logic lr, input logic f);
    iq_empty = e; id_valid = v; id_is_ls = ls;
    rob_commit = c; rs_release = rr; lsb_release = lr; flush = f;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1;
    drv(1, 0, 0, 0, 0, 0, 0);
    tick; tick;
    exp_out("reset", 0, 0, 1, 0, 0);
    rst = 1'b0;

    // Three ALU ops back-to-back, then fill ROB and RS to 16.
    for (int i = 1; i <= 3; i++) begin
      drv(0, 1, 0, 0, 0, 0, 0);
      exp_out("alu3", 1, 0, i, 0, 0);
      tick;
    end
    for (int i = 4; i <= 16; i++) begin
      drv(0, 1, 0, 0, 0, 0, 0);
      exp_out("fill_rob", 1, 0, i, 0, 0);
      tick;
    end
    drv(0, 1, 0, 0, 0, 0, 0);
    exp_out("rob_full_hold", 0, 0, 1, 1, 1);
    tick;
    // Commit frees a ROB slot only from the next cycle; RS still full so use a load.
    drv(0, 1, 1, 1, 0, 0, 0);
    exp_out("commit_same_cycle", 0, 0, 1, 1, 1);
    tick;
    drv(0, 1, 1, 0, 0, 0, 0);
    exp_out("wrap_tag", 1, 1, 1, 0, 0);
    tick;

    // Flush clears all counts; head=1 so tail=1.
    drv(0, 1, 0, 0, 0, 0, 1);
    exp_out("flush_cycle", 0, 0, 2, 1, 1);
    tick;
    drv(0, 1, 0, 1, 1, 0, 0);
    exp_out("flush_state", 0, 0, 2, 0, 1);
    tick;

    // Fill LSB with 16 loads while committing to keep ROB occupancy at 1.
    for (int i = 0; i < 16; i++) begin
      drv(0, 1, 1, 1, 0, 0, 0);
      exp_out("fill_lsb", 1, 1, ((1 + i) % 16) + 1, 0, 0);
      tick;
    end
    drv(0, 1, 1, 0, 0, 0, 0);
    exp_out("lsb_full", 0, 0, 2, 0, 1);
    tick;
    drv(0, 1, 0, 0, 0, 0, 0);
    exp_out("alu_past_lsb", 1, 0, 2, 0, 0);
    tick;
    drv(0, 1, 1, 0, 0, 1, 0);
    exp_out("lsb_rel_same", 0, 0, 3, 0, 1);
    tick;
    drv(0, 1, 1, 0, 0, 0, 0);
    exp_out("lsb_rel_next", 1, 1, 3, 0, 0);
    tick;

    // Bring rs_count to 5 (ROB to 7), then 10 cycles of issue+release+commit.
    for (int i = 0; i < 4; i++) begin
      drv(0, 1, 0, 0, 0, 0, 0);
      exp_out("rs_to5", 1, 0, 4 + i, 0, 0);
      tick;
    end
    for (int i = 0; i < 10; i++) begin
      drv(0, 1, 0, 1, 1, 0, 0);
      exp_out("rs_steady", 1, 0, ((7 + i) % 16) + 1, 0, 0);
      tick;
    end
    // rs_count must still be 5: exactly 11 more ALU ops fit.
    for (int i = 0; i < 11; i++) begin
      drv(0, 1, 0, 1, 0, 0, 0);
      exp_out("rs_probe", 1, 0, ((1 + i) % 16) + 1, 0, 0);
      tick;
    end
    drv(0, 1, 0, 0, 0, 0, 0);
    exp_out("rs_full", 0, 0, 13, 0, 1);
    tick;

    // rob_count=7, head=5: flush with commit -> head=tail=6, next tag 7.
    drv(0, 1, 0, 1, 0, 0, 1);
    exp_out("flush_commit", 0, 0, 13, 0, 1);
    tick;
    drv(0, 1, 0, 1, 1, 0, 0);
    exp_out("flush_hold", 0, 0, 7, 0, 1);
    tick;
    // Counts restarted at 0: 16 ALU ops fit, the 17th is blocked.
    for (int i = 0; i < 16; i++) begin
      drv(0, 1, 0, 0, 0, 0, 0);
      exp_out("restart", 1, 0, ((6 + i) % 16) + 1, 0, 0);
      tick;
    end
    drv(0, 1, 0, 0, 0, 0, 0);
    exp_out("restart_full", 0, 0, 7, 1, 1);
    tick;

    // Clear again, then exercise rdy freeze (including an ignored flush).
    drv(1, 0, 0, 0, 0, 0, 1);
    tick;
    drv(1, 0, 0, 0, 0, 0, 0);
    tick;
    rdy = 1'b0;
    drv(0, 1, 0, 0, 0, 0, 0);
    exp_out("rdy_low", 0, 0, 7, 0, 0);
    tick; tick;
    drv(0, 1, 0, 0, 0, 0, 1);
    exp_out("rdy_low_flush", 0, 0, 7, 0, 0);
    tick;
    rdy = 1'b1;
    drv(0, 1, 0, 0, 0, 0, 0);
    exp_out("rdy_resume", 1, 0, 7, 0, 0);
    tick;

    // Mid-stream reset.
    rst = 1'b1;
    drv(0, 1, 0, 0, 0, 0, 0);
    tick;
    rst = 1'b0;
    drv(1, 0, 0, 0, 0, 0, 0);
    exp_out("mid_reset", 0, 0, 1, 0, 0);
    drv(0, 1, 0, 0, 0, 0, 0);
    exp_out("post_reset", 1, 0, 1, 0, 0);
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
